// File: rtl/proc_pkg.sv
// proc_pkg: shared helpers for the pipelined datapath blocks.
package proc_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// mux2_cell: gate-level 1-bit 2:1 mux cell used by the gate-level datapath.
module mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    logic sn, t0, t1;
    not g_n  (sn, s);
    and g_a0 (t0, d0, sn);
    and g_a1 (t1, d1, s);
    or  g_o  (y, t0, t1);
endmodule

// File: rtl/mux_tree_level.sv
// mux_tree_level: one registered halving level of the mux tree, steered by sel bit K.
module mux_tree_level #(
    parameter int WIDTH = 64,
    parameter int N_IN = 4,
    parameter int SEL_W = 2,
    parameter int K = 0,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [N_IN*WIDTH-1:0]  data_in,
    output logic                   valid_out,
    output logic [SEL_W-1:0]       sel_out,
    output logic [N_OUT*WIDTH-1:0] data_out
);
    localparam int PW = 2 * N_OUT * WIDTH;
    logic [PW-1:0]          padded;
    logic [N_OUT*WIDTH-1:0] picked;
    // an odd input count pairs its last word with a zero word
    assign padded = PW'(data_in);
    for (genvar j = 0; j < N_OUT; j++) begin : g_w
        for (genvar i = 0; i < WIDTH; i++) begin : g_b
            mux2_cell u_mux (
                .d0(padded[2*j*WIDTH + i]),
                .d1(padded[(2*j+1)*WIDTH + i]),
                .s (sel_in[K]),
                .y (picked[j*WIDTH + i])
            );
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            sel_out   <= '0;
            data_out  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            sel_out   <= sel_in;
            data_out  <= picked;
        end
    end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N-input W-bit binary mux tree with a register after every level.
module mux_tree_pipe import proc_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN),
    localparam int LEVELS = SEL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel
);
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = (NUM_IN + (1 << k) - 1) >> k;
        localparam int NO = (NI + 1) / 2;
        logic [NO*WIDTH-1:0] d;
        logic                v;
        logic [SEL_W-1:0]    s;
        if (k == 0) begin : g_first
            mux_tree_level #(.WIDTH(WIDTH), .N_IN(NI), .SEL_W(SEL_W), .K(k)) u_lvl (
                .clk(clk), .reset(reset), .en(en), .flush(flush),
                .valid_in(in_valid), .sel_in(sel), .data_in(data_in),
                .valid_out(v), .sel_out(s), .data_out(d)
            );
        end else begin : g_next
            mux_tree_level #(.WIDTH(WIDTH), .N_IN(NI), .SEL_W(SEL_W), .K(k)) u_lvl (
                .clk(clk), .reset(reset), .en(en), .flush(flush),
                .valid_in(g_lvl[k-1].v), .sel_in(g_lvl[k-1].s), .data_in(g_lvl[k-1].d),
                .valid_out(v), .sel_out(s), .data_out(d)
            );
        end
    end
    assign out       = g_lvl[LEVELS-1].d;
    assign out_valid = g_lvl[LEVELS-1].v;
    assign out_sel   = g_lvl[LEVELS-1].s;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed checks of a 4-input and a 5-input 8-bit mux tree pipeline.
module tb_mux_tree_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1, en = 1'b1, flush = 1'b0;
    logic        iv_a = 1'b0, iv_b = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [2:0]  sel_b = '0;
    logic [31:0] data_a = '0;
    logic [39:0] data_b = '0;
    logic [7:0]  out_a, out_b;
    logic        ov_a, ov_b;
    logic [1:0]  os_a;
    logic [2:0]  os_b;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.WIDTH(8), .NUM_IN(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(iv_a),
        .sel(sel_a), .data_in(data_a), .out(out_a), .out_valid(ov_a), .out_sel(os_a)
    );
    mux_tree_pipe #(.WIDTH(8), .NUM_IN(5)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(iv_b),
        .sel(sel_b), .data_in(data_b), .out(out_b), .out_valid(ov_b), .out_sel(os_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(ov_a), 32'(v));
        if (v) begin
            chk({tag, ".out"}, 32'(out_a), 32'(d));
            chk({tag, ".sel"}, 32'(os_a), 32'(s));
        end
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [7:0] d, input logic [2:0] s);
        chk({tag, ".valid"}, 32'(ov_b), 32'(v));
        if (v) begin
            chk({tag, ".out"}, 32'(out_b), 32'(d));
            chk({tag, ".sel"}, 32'(os_b), 32'(s));
        end
    endtask

    initial begin
        logic [7:0] exp_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        data_a = $urandom;
        data_b = {8'(($urandom)), 32'($urandom)};
        sel_a = 2'($urandom_range(0, 3));
        iv_a = 1'b1;
        iv_b = 1'b1;
        tick();
        tick();
        chk("rst.a.out", 32'(out_a), 32'h0);
        chk("rst.a.valid", 32'(ov_a), 32'h0);
        chk("rst.a.sel", 32'(os_a), 32'h0);
        chk("rst.b.out", 32'(out_b), 32'h0);
        chk("rst.b.valid", 32'(ov_b), 32'h0);
        reset = 1'b0;
        iv_a = 1'b0;
        iv_b = 1'b0;
        tick();
        chk("post_rst.out", 32'(out_a), 32'h0);
        chk("post_rst.valid", 32'(ov_a), 32'h0);
        chk("post_rst.sel", 32'(os_a), 32'h0);

        data_a = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 6; i++) begin
            iv_a = (i < 4);
            sel_a = 2'(i);
            tick();
            if (i >= 1 && i <= 4) chk_a("stream", 1'b1, exp_a[i-1], 2'(i-1));
            if (i == 5) chk_a("stream.drain", 1'b0, 8'h0, 2'h0);
        end

        iv_a = 1'b1;
        sel_a = 2'd3;
        tick();
        sel_a = 2'd1;
        tick();
        chk_a("stall.pre", 1'b1, 8'h44, 2'd3);
        en = 1'b0;
        sel_a = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("stall.hold", 1'b1, 8'h44, 2'd3);
        end
        en = 1'b1;
        iv_a = 1'b0;
        tick();
        chk_a("stall.resume", 1'b1, 8'h22, 2'd1);
        tick();
        chk_a("stall.nodup", 1'b0, 8'h0, 2'h0);

        iv_a = 1'b1;
        sel_a = 2'd2;
        tick();
        sel_a = 2'd0;
        tick();
        chk_a("flush.pre", 1'b1, 8'h33, 2'd2);
        flush = 1'b1;
        iv_a = 1'b0;
        tick();
        chk_a("flush.c1", 1'b0, 8'h0, 2'h0);
        flush = 1'b0;
        iv_a = 1'b1;
        sel_a = 2'd1;
        tick();
        chk_a("flush.c2", 1'b0, 8'h0, 2'h0);
        iv_a = 1'b0;
        tick();
        chk_a("flush.after", 1'b1, 8'h22, 2'd1);
        tick();
        chk_a("flush.drain", 1'b0, 8'h0, 2'h0);

        iv_a = 1'b1;
        sel_a = 2'd3;
        tick();
        iv_a = 1'b0;
        en = 1'b0;
        flush = 1'b1;
        tick();
        en = 1'b1;
        flush = 1'b0;
        chk_a("flush_over_en.c1", 1'b0, 8'h0, 2'h0);
        tick();
        chk_a("flush_over_en.c2", 1'b0, 8'h0, 2'h0);

        data_b = {8'hA5, 8'h40, 8'h30, 8'h20, 8'h10};
        iv_b = 1'b1;
        sel_b = 3'd4;
        tick();
        sel_b = 3'd6;
        tick();
        sel_b = 3'd5;
        tick();
        chk_b("n5.sel4", 1'b1, 8'hA5, 3'd4);
        iv_b = 1'b0;
        tick();
        chk_b("n5.sel6", 1'b1, 8'h00, 3'd6);
        tick();
        chk_b("n5.sel5", 1'b1, 8'h00, 3'd5);
        tick();
        chk_b("n5.drain", 1'b0, 8'h0, 3'h0);

        iv_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = 2'(i);
            tick();
        end
        chk_a("mid_rst.pre", 1'b1, 8'h22, 2'd1);
        reset = 1'b1;
        sel_a = 2'd3;
        tick();
        chk("mid_rst.out", 32'(out_a), 32'h0);
        chk("mid_rst.valid", 32'(ov_a), 32'h0);
        chk("mid_rst.sel", 32'(os_a), 32'h0);
        reset = 1'b0;
        sel_a = 2'd1;
        tick();
        chk_a("mid_rst.c1", 1'b0, 8'h0, 2'h0);
        iv_a = 1'b0;
        tick();
        chk_a("mid_rst.new", 1'b1, 8'h22, 2'd1);
        tick();
        chk_a("mid_rst.drain", 1'b0, 8'h0, 2'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N-input, W-bit multiplexer built as a binary tree of 2:1 levels, with a pipeline register after every tree level.
- Used in the pipelined processor wherever wide selection sits on a timing-critical path: register-file read-port select, writeback-source select, forwarding select.
- Carries a valid bit and the unconsumed select bits alongside the data, and supports stall (hold) and flush.

Parameters:
- WIDTH, 64, data bits per input.
- NUM_IN, 4, number of inputs, 2..32; need not be a power of two.
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden).
- LEVELS, SEL_W, number of tree levels and pipeline stages (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; 0 = every stage register holds its value.
- flush  in  1  clears all valid bits; data registers are don't-care afterwards.
- in_valid  in  1  input word qualifier.
- sel  in  SEL_W  input index, sampled with in_valid.
- data_in  in  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- out  out  WIDTH  selected data.
- out_valid  out  1  out holds a valid result.
- out_sel  out  SEL_W  the sel value that produced out (debug/forwarding tag).

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset: every stage data register, valid bit and select register goes to 0, so out=0, out_valid=0 and out_sel=0 on the cycle after reset is sampled. Reset has priority over flush, and flush has priority over en.
- Inputs are padded to 2^SEL_W with zero words. A sel value >= NUM_IN yields out=0 with out_valid=1, and out_sel reports that sel value.
- Level k (k=0..LEVELS-1) pairs the words of level k-1 using sel bit k:
  - bit k = 0 takes the lower-index word, 1 takes the higher.
  - Level 0 operates on data_in.
  - Each level ends in a register bank holding the surviving words, valid, and the full sel.
- Latency is exactly LEVELS cycles when en is held at 1 (NUM_IN=2 gives 1 cycle; NUM_IN=5..8 gives 3 cycles).
- Throughput is one word per cycle; there is no bubble insertion.
- en=0: all stage registers, including valid, hold. Inputs presented during that cycle are ignored. Outputs stay constant for the whole stall.
- flush=1 (regardless of en): all stage valid bits clear at the next edge, so out_valid=0 from the next cycle. Data and sel registers may retain or update; they are don't-care while valid=0.
- in_valid=0 still propagates data through the tree; the stage valid bit is simply 0. out is don't-care whenever out_valid=0.
- The pipeline has no ready/back-pressure signal. The consumer drives en.
- Reset asserted mid-stream discards all in-flight words. Words presented in the reset cycle are lost, and the first word accepted is the one present on the first cycle with reset=0 and en=1.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package (proc_pkg): function clog2_min1(n), which returns max(1, $clog2(n)); no typedefs are needed.
- One sub-module: mux_tree_level, which takes WIDTH and an input count and implements one registered halving level with valid/sel pass-through.
  - Its 2:1 selection is a generate array of the existing gate-level 1-bit 2:1 mux cell (DELAY kept at the cell default), so it stays consistent with the gate-level datapath.
- mux_tree_pipe instantiates LEVELS copies of mux_tree_level in a generate loop.

Test Plan (WIDTH=8, NUM_IN=4, LEVELS=2 unless noted):
- Apply reset for 2 cycles with random inputs -> out=0x00, out_valid=0, out_sel=0 during and one cycle after reset.
- Inputs {0x11,0x22,0x33,0x44}; sel=0,1,2,3 on consecutive cycles, en=1, in_valid=1 -> out=0x11,0x22,0x33,0x44 on cycles 2,3,4,5 after the first input, each with out_valid=1 and matching out_sel.
- Stream sel=3 then sel=1; drop en for 3 cycles after the first word enters -> outputs frozen during the stall; the sequence resumes with 0x44 then 0x22, no duplicates and no drops.
- Two valid words in flight, flush=1 for one cycle -> out_valid=0 on the next 2 cycles; a word issued in the cycle after flush emerges valid 2 cycles later.
- NUM_IN=5, WIDTH=8, LEVELS=3: sel=4 with input4=0xA5 -> 0xA5 after 3 cycles; sel=6 -> out=0x00, out_valid=1, out_sel=6.
- Three words in flight, reset pulsed for 1 cycle with en=1 -> out_valid=0 until a new word traverses; no pre-reset word ever appears.
